// File: rtl/hall_call_registry.sv
// Hall call registry: debounces a call button, latches up/down hall calls per
// floor, clears them on car arrival and tracks the car's travel direction.
`timescale 1ns/1ps
module hall_call_registry #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic               dir_up,
  input  logic [FLOOR_W-1:0] floor_sel,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               arrive,
  output logic [FLOORS-1:0]  up_req,
  output logic [FLOORS-1:0]  down_req,
  output logic [1:0]         up_or_down,
  output logic               accept,
  output logic               reject
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, DOWN = 2'b10, UP = 2'b11} dir_t;

  dir_t              state, state_nxt;
  logic              rst_meta, rst_ok;
  logic              btn_p0, btn_p1, deb_level;
  logic [CNT_W-1:0]  deb_cnt;
  logic              call_evt, call_ok, call_bad;
  logic              above, below;
  logic [FLOORS-1:0] up_set, dn_set, up_clr, dn_clr, arr_mask;

  function automatic logic call_valid(input logic up, input logic [FLOOR_W-1:0] fl);
    if (int'(fl) >= FLOORS)                      return 1'b0;
    if (up && (int'(fl) == FLOORS - 1))          return 1'b0;
    if (!up && (fl == '0))                       return 1'b0;
    return 1'b1;
  endfunction

  // Out-of-range indices yield an all-zero mask, which makes such arrivals no-ops.
  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] idx);
    logic [FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < FLOORS; i++)
      if (int'(idx) == i) v[i] = 1'b1;
    return v;
  endfunction

  // Reset release is synchronised; nothing else moves until rst_ok is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta <= 1'b0;
      rst_ok   <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_ok   <= rst_meta;
    end
  end

  // Stage p0/p1: button synchroniser, then stability counter on the synced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0    <= 1'b0;
      btn_p1    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (rst_ok) begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      if (btn_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
        deb_level <= btn_p1;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign call_evt = rst_ok && !deb_level && btn_p1 && (deb_cnt == CNT_LAST);

  always_comb begin
    call_ok  = call_evt && call_valid(dir_up, floor_sel);
    call_bad = call_evt && !call_valid(dir_up, floor_sel);
    up_set   = (call_ok && dir_up)  ? onehot(floor_sel) : '0;
    dn_set   = (call_ok && !dir_up) ? onehot(floor_sel) : '0;
    arr_mask = (rst_ok && arrive)   ? onehot(cur_floor) : '0;
    up_clr   = (state != DOWN) ? arr_mask : '0;
    dn_clr   = (state != UP)   ? arr_mask : '0;
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (up_req[i] || down_req[i]) begin
        if (i > int'(cur_floor)) above = 1'b1;
        if (i < int'(cur_floor)) below = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = above ? UP   : (below ? DOWN : IDLE);
      UP:      state_nxt = above ? UP   : (below ? DOWN : IDLE);
      DOWN:    state_nxt = below ? DOWN : (above ? UP   : IDLE);
      default: state_nxt = IDLE;
    endcase
  end

  // Set is OR-ed in after the clear so a simultaneous call survives an arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_req   <= '0;
      down_req <= '0;
      state    <= IDLE;
      accept   <= 1'b0;
      reject   <= 1'b0;
    end else if (rst_ok) begin
      up_req   <= (up_req & ~up_clr) | up_set;
      down_req <= (down_req & ~dn_clr) | dn_set;
      state    <= state_nxt;
      accept   <= call_ok;
      reject   <= call_bad;
    end
  end

  assign up_or_down = state;

endmodule

// File: tb/tb_hall_call_registry.sv
// Randomised scoreboard bench for hall_call_registry with a floor-array reference model.
`timescale 1ns/1ps
module tb_hall_call_registry;

  localparam int FLOORS = 4;
  localparam int FW     = 2;
  localparam int DEB    = 4;
  localparam int MD_IDLE = 0, MD_UP = 1, MD_DOWN = 2;

  logic              clk, rst_n, btn, dir_up, arrive;
  logic [FW-1:0]     floor_sel, cur_floor;
  logic [FLOORS-1:0] up_req, down_req;
  logic [1:0]        up_or_down;
  logic              accept, reject;

  hall_call_registry #(.FLOORS(FLOORS), .FLOOR_W(FW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .dir_up(dir_up), .floor_sel(floor_sel),
    .cur_floor(cur_floor), .arrive(arrive), .up_req(up_req), .down_req(down_req),
    .up_or_down(up_or_down), .accept(accept), .reject(reject)
  );

  typedef struct { bit acc; bit d; int fl; int dmin; int dmax; } exp_t;
  exp_t q[$];

  int total = 0, bad = 0, cyc = 0;
  bit done = 0, rand_on = 0;
  bit m_up[FLOORS], m_dn[FLOORS];
  int m_dir = MD_IDLE;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [FLOORS-1:0] pack(input bit a[FLOORS]);
    logic [FLOORS-1:0] v;
    for (int i = 0; i < FLOORS; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [1:0] enc(input int d);
    return (d == MD_UP) ? 2'b11 : ((d == MD_DOWN) ? 2'b10 : 2'b00);
  endfunction

  function automatic bit is_valid(input bit d, input int fl);
    if (fl >= FLOORS)                return 0;
    if (d && fl == FLOORS - 1)       return 0;
    if (!d && fl == 0)               return 0;
    return 1;
  endfunction

  // Reference model: one clock edge of the elevator rules, applied to the arrays.
  function automatic void model_step();
    bit ab = 0, be = 0;
    int cf = int'(cur_floor);
    for (int i = 0; i < FLOORS; i++)
      if (m_up[i] || m_dn[i]) begin
        if (i > cf) ab = 1;
        if (i < cf) be = 1;
      end
    if (arrive && cf < FLOORS) begin
      if (m_dir != MD_DOWN) m_up[cf] = 0;
      if (m_dir != MD_UP)   m_dn[cf] = 0;
    end
    if (m_dir == MD_DOWN) m_dir = be ? MD_DOWN : (ab ? MD_UP : MD_IDLE);
    else                  m_dir = ab ? MD_UP : (be ? MD_DOWN : MD_IDLE);
  endfunction

  // Monitor: owns the model, the scoreboard pops and all counters.
  initial begin
    exp_t e;
    forever begin
      @(clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        for (int i = 0; i < FLOORS; i++) begin m_up[i] = 0; m_dn[i] = 0; end
        m_dir = MD_IDLE;
        chk("rst_up_req", 32'(up_req), 0);
        chk("rst_down_req", 32'(down_req), 0);
        chk("rst_dir", 32'(up_or_down), 0);
        chk("rst_accept", 32'(accept), 0);
        chk("rst_reject", 32'(reject), 0);
      end else if (clk) begin
        model_step();
        cyc++;
      end else begin
        if (accept && reject) chk("accept_and_reject", 1, 0);
        if (q.size() > 0 && cyc > q[0].dmax) begin
          chk("call_deadline", 32'(cyc), 32'(q[0].dmax));
          void'(q.pop_front());
        end
        if (accept || reject) begin
          if (q.size() == 0) begin
            chk("unexpected_event", {30'd0, accept, reject}, 0);
          end else begin
            e = q.pop_front();
            chk("event_kind_accept", 32'(accept), 32'(e.acc));
            chk("event_latency_ok", 32'(cyc >= e.dmin && cyc <= e.dmax), 1);
            if (e.acc) begin
              if (e.d) m_up[e.fl] = 1;
              else     m_dn[e.fl] = 1;
            end
          end
        end
        chk("up_req", 32'(up_req), 32'(pack(m_up)));
        chk("down_req", 32'(down_req), 32'(pack(m_dn)));
        chk("up_or_down", 32'(up_or_down), 32'(enc(m_dir)));
        if (done) begin
          chk("events_outstanding", 32'(q.size()), 0);
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_on) begin
      arrive = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) cur_floor = FW'($urandom_range(0, FLOORS - 1));
    end
  endtask

  task automatic push(input bit d, input int fl, input int lo, input int hi);
    exp_t e;
    e.acc = is_valid(d, fl); e.d = d; e.fl = fl; e.dmin = lo; e.dmax = hi;
    q.push_back(e);
  endtask

  task automatic press(input bit d, input int fl, input int len);
    dir_up = d; floor_sel = FW'(fl); btn = 1'b1;
    push(d, fl, cyc + 2 + DEB, cyc + 2 + DEB);
    repeat (len) tick();
    btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic arrive_at(input int fl);
    cur_floor = FW'(fl); arrive = 1'b1;
    tick();
    arrive = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; btn = 1'b0; dir_up = 1'b0; floor_sel = '0; cur_floor = '0; arrive = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    press(1, 2, 10);                       // up call at 2 from floor 0
    btn = 1'b1; tick(); tick(); btn = 1'b0; // short glitch
    repeat (12) tick();
    press(1, 3, 10);                       // up at top floor
    press(0, 0, 10);                       // down at ground floor
    press(0, 1, 10);
    arrive_at(2);
    arrive_at(1);

    cur_floor = 2'd3;                      // call at the car's own floor while idle
    press(0, 3, 10);
    repeat (5) tick();
    arrive_at(3);

    cur_floor = 2'd1;                      // set and clear of up_req[1] on one edge
    press(0, 3, 10);
    dir_up = 1'b1; floor_sel = 2'd1; btn = 1'b1;
    push(1, 1, cyc + 2 + DEB, cyc + 2 + DEB);
    repeat (5) tick();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    repeat (6) tick();
    btn = 1'b0;
    repeat (12) tick();

    cur_floor = 2'd0;                      // reset pulse while travelling and mid-debounce
    press(1, 2, 10);
    dir_up = 1'b0; floor_sel = 2'd3; btn = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push(0, 3, cyc + 2 + DEB, cyc + 4 + DEB);
    repeat (14) tick();
    btn = 1'b0;
    repeat (12) tick();

    rand_on = 1'b1;
    for (int n = 0; n < 40; n++)
      press(1'($urandom_range(0, 1)), $urandom_range(0, FLOORS - 1), $urandom_range(8, 14));
    rand_on = 1'b0;
    arrive = 1'b0;
    repeat (10) tick();
    done = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor_stalled actual=running required=finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
